// File: rtl/sub_pkg.sv
// Shared definitions for the subtract/saturate datapath family.
// Mode encoding, stage-depth limits and signed-bound helpers.
package sub_pkg;

  typedef enum logic {
    MODE_UNSIGNED = 1'b0,
    MODE_SIGNED   = 1'b1
  } sub_mode_e;

  localparam int unsigned DATAWIDTH_MIN = 2;
  localparam int unsigned STAGES_MIN    = 1;
  localparam int unsigned STAGES_MAX    = 4;

  // Helpers return a 64-bit pattern; callers truncate to their width (<= 64).
  localparam int unsigned HELPER_W = 64;

  function automatic logic [HELPER_W-1:0] signed_max(input int unsigned width);
    return (HELPER_W'(1) << (width - 1)) - HELPER_W'(1);
  endfunction

  function automatic logic [HELPER_W-1:0] signed_min(input int unsigned width);
    return HELPER_W'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/sub_sat_core.sv
// Combinational subtract with signed/unsigned overflow detection and optional clamp.
module sub_sat_core
  import sub_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic                 is_signed,
  input  logic                 saturate,
  output logic [DATAWIDTH-1:0] diff,
  output logic                 borrow,
  output logic                 overflow
);

  localparam int unsigned MSB = DATAWIDTH - 1;

  // Built by replication so the core stays width-agnostic beyond 64 bits.
  localparam logic [DATAWIDTH-1:0] SMAX = {1'b0, {(DATAWIDTH-1){1'b1}}};
  localparam logic [DATAWIDTH-1:0] SMIN = {1'b1, {(DATAWIDTH-1){1'b0}}};

  logic [DATAWIDTH-1:0] raw;
  sub_mode_e            mode;

  always_comb begin
    mode   = sub_mode_e'(is_signed);
    raw    = a - b;
    borrow = (a < b);
    if (mode == MODE_SIGNED) begin
      overflow = (a[MSB] != b[MSB]) && (raw[MSB] != a[MSB]);
    end else begin
      overflow = borrow;
    end

    diff = raw;
    if (saturate && overflow) begin
      if (mode == MODE_SIGNED) begin
        diff = a[MSB] ? SMIN : SMAX;
      end else begin
        diff = '0;
      end
    end
  end

endmodule

// File: rtl/sub_pipe.sv
// Pipelined subtractor: arithmetic captured in stage 1, later stages only delay,
// valid/ready handshake with back-pressure and bubble collapse.
module sub_pipe
  import sub_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned STAGES    = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic                 is_signed,
  input  logic                 saturate,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] diff,
  output logic                 borrow,
  output logic                 overflow
);

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("sub_pipe: STAGES out of range");
  end
  if (DATAWIDTH < DATAWIDTH_MIN) begin : g_bad_width
    $error("sub_pipe: DATAWIDTH out of range");
  end

  typedef struct packed {
    logic [DATAWIDTH-1:0] diff;
    logic                 borrow;
    logic                 overflow;
  } beat_t;

  beat_t             core_res;
  beat_t             stage_q [STAGES];
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] adv;

  sub_sat_core #(
    .DATAWIDTH(DATAWIDTH)
  ) u_core (
    .a        (a),
    .b        (b),
    .is_signed(is_signed),
    .saturate (saturate),
    .diff     (core_res.diff),
    .borrow   (core_res.borrow),
    .overflow (core_res.overflow)
  );

  // A stage is blocked only when every stage after it is full and the sink stalls;
  // walking from the output end avoids a combinational chain through adv itself.
  always_comb begin
    logic blocked;
    blocked = !out_ready;
    adv     = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      adv[STAGES-1-i] = vld[STAGES-1-i] && !blocked;
      blocked         = blocked && vld[STAGES-1-i];
    end
  end

  assign in_ready = !Rst && (!vld[0] || adv[0]);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      vld <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      if (in_ready) begin
        vld[0] <= in_valid;
      end
      if (in_valid && in_ready) begin
        stage_q[0] <= core_res;
      end
      for (int unsigned k = 1; k < STAGES; k++) begin
        if (adv[k-1]) begin
          vld[k]     <= 1'b1;
          stage_q[k] <= stage_q[k-1];
        end else if (adv[k]) begin
          vld[k] <= 1'b0;
        end
      end
    end
  end

  assign out_valid = vld[STAGES-1];
  assign diff      = stage_q[STAGES-1].diff;
  assign borrow    = stage_q[STAGES-1].borrow;
  assign overflow  = stage_q[STAGES-1].overflow;

endmodule
